// File: rtl/fb_bus_arbiter_pkg.sv
// Shared types for the framebuffer SRAM bus arbiter.
package fb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_VID
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_ACCESS
    } arb_state_t;

    // Requester to serve from the current request levels; a tie goes to the
    // side that was not granted last.
    function automatic owner_t pick_owner(logic cpu_req, logic vid_req, owner_t last_grant);
        owner_t pick;
        pick = OWN_NONE;
        if (cpu_req && vid_req) begin
            pick = (last_grant == OWN_CPU) ? OWN_VID : OWN_CPU;
        end else if (cpu_req) begin
            pick = OWN_CPU;
        end else if (vid_req) begin
            pick = OWN_VID;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fb_bus_arbiter_if.sv
// Request/ack handshakes and SRAM bus control strobes of the framebuffer arbiter.
interface fb_bus_arbiter_if;

    logic cpu_req;
    logic cpu_we;
    logic cpu_ack;
    logic vid_req;
    logic vid_ack;
    logic sw_oe1_n;
    logic sw_oe2_n;
    logic ram_oe_n;
    logic ram_we_n;
    logic lat_en_n;

    // Arbiter side: consumes requests, drives acks and bus control.
    modport master (
        input  cpu_req,
        input  cpu_we,
        input  vid_req,
        output cpu_ack,
        output vid_ack,
        output sw_oe1_n,
        output sw_oe2_n,
        output ram_oe_n,
        output ram_we_n,
        output lat_en_n
    );

    // Requester / bus side.
    modport slave (
        output cpu_req,
        output cpu_we,
        output vid_req,
        input  cpu_ack,
        input  vid_ack,
        input  sw_oe1_n,
        input  sw_oe2_n,
        input  ram_oe_n,
        input  ram_we_n,
        input  lat_en_n
    );

endinterface

// File: rtl/fb_bus_arbiter_cycle_counter.sv
// Loadable down-counter timing both the dead gap and the SRAM access window.
module fb_cycle_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;

    // Load on phase entry, otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == '0);

endmodule

// File: rtl/fb_bus_arbiter.sv
// Framebuffer SRAM bus arbiter: CPU (switch path 1) vs video fetch (path 2),
// break-before-make ownership changes and registered control strobes.
module fb_bus_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ACC_CYCLES  = 2,
    parameter int unsigned DEAD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    fb_bus_arbiter_if.master  bus
);

    localparam int unsigned CNT_MAX = (ACC_CYCLES > DEAD_CYCLES) ? ACC_CYCLES : DEAD_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] ACC_LOAD = CW'(ACC_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(DEAD_CYCLES - 1);

    arb_state_t state_q, state_d;
    owner_t     own_q, own_d;
    owner_t     last_q, last_d;
    owner_t     tgt_q, tgt_d;
    owner_t     req_pick;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic [CW-1:0] cnt;
    logic          cnt_done;
    logic          fin_d;

    logic sw1_q, sw1_d;
    logic sw2_q, sw2_d;
    logic oe_q, oe_d;
    logic we_q, we_d;
    logic lat_q, lat_d;
    logic cack_q, cack_d;
    logic vack_q, vack_d;

    fb_cycle_counter #(
        .WIDTH(CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .done     (cnt_done)
    );

    // Next state, ownership, grant history and counter loads.
    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        last_d       = last_q;
        tgt_d        = tgt_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        req_pick     = pick_owner(bus.cpu_req, bus.vid_req, last_q);
        case (state_q)
            ST_IDLE: begin
                if (req_pick != OWN_NONE) begin
                    if (own_q == OWN_NONE || own_q == req_pick) begin
                        own_d        = req_pick;
                        last_d       = req_pick;
                        state_d      = ST_ACCESS;
                        cnt_load     = 1'b1;
                        cnt_load_val = ACC_LOAD;
                    end else begin
                        own_d        = OWN_NONE;
                        tgt_d        = req_pick;
                        state_d      = ST_GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_done) begin
                    own_d        = tgt_q;
                    last_d       = tgt_q;
                    state_d      = ST_ACCESS;
                    cnt_load     = 1'b1;
                    cnt_load_val = ACC_LOAD;
                end
            end
            ST_ACCESS: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decode the strobes for the coming cycle so every output leaves a flop;
    // the counter runs down, so the final access cycle is the one at zero.
    always_comb begin
        fin_d  = (state_d == ST_ACCESS) &&
                 (cnt_load ? (cnt_load_val == '0) : (cnt == CW'(1)));
        sw1_d  = (own_d != OWN_CPU);
        sw2_d  = (own_d != OWN_VID);
        oe_d   = 1'b1;
        we_d   = 1'b1;
        lat_d  = 1'b1;
        cack_d = 1'b0;
        vack_d = 1'b0;
        if (state_d == ST_ACCESS) begin
            if (own_d == OWN_CPU) begin
                cack_d = fin_d;
                if (bus.cpu_we) begin
                    we_d = fin_d;
                end else begin
                    oe_d = 1'b0;
                end
            end else if (own_d == OWN_VID) begin
                vack_d = fin_d;
                oe_d   = 1'b0;
                lat_d  = ~fin_d;
            end
        end
    end

    // State and registered outputs; reset forces the bus idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            own_q   <= OWN_NONE;
            last_q  <= OWN_VID;
            tgt_q   <= OWN_NONE;
            sw1_q   <= 1'b1;
            sw2_q   <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            lat_q   <= 1'b1;
            cack_q  <= 1'b0;
            vack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            tgt_q   <= tgt_d;
            sw1_q   <= sw1_d;
            sw2_q   <= sw2_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            lat_q   <= lat_d;
            cack_q  <= cack_d;
            vack_q  <= vack_d;
        end
    end

    assign bus.sw_oe1_n = sw1_q;
    assign bus.sw_oe2_n = sw2_q;
    assign bus.ram_oe_n = oe_q;
    assign bus.ram_we_n = we_q;
    assign bus.lat_en_n = lat_q;
    assign bus.cpu_ack  = cack_q;
    assign bus.vid_ack  = vack_q;

endmodule

// File: tb/tb_fb_bus_arbiter.sv
// Directed self-checking bench for fb_bus_arbiter (ACC_CYCLES=2, DEAD_CYCLES=1).
// obs = {sw_oe1_n, sw_oe2_n, ram_oe_n, ram_we_n, lat_en_n, cpu_ack, vid_ack}
module tb_fb_bus_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fb_bus_arbiter_if bus_if ();

    fb_bus_arbiter #(
        .ACC_CYCLES  (2),
        .DEAD_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic [6:0] obs;
    assign obs = {bus_if.sw_oe1_n, bus_if.sw_oe2_n, bus_if.ram_oe_n, bus_if.ram_we_n,
                  bus_if.lat_en_n, bus_if.cpu_ack, bus_if.vid_ack};

    localparam logic [6:0] IDLE_OFF  = 7'b1111100;
    localparam logic [6:0] VID_ACC   = 7'b1001100;
    localparam logic [6:0] VID_FIN   = 7'b1001001;
    localparam logic [6:0] VID_PARK  = 7'b1011100;
    localparam logic [6:0] CPU_RD    = 7'b0101100;
    localparam logic [6:0] CPU_RDFIN = 7'b0101110;
    localparam logic [6:0] CPU_WR    = 7'b0110100;
    localparam logic [6:0] CPU_WRFIN = 7'b0111110;
    localparam logic [6:0] CPU_PARK  = 7'b0111100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        bus_if.cpu_req = 1'b0;
        bus_if.cpu_we  = 1'b0;
        bus_if.vid_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== IDLE_OFF) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %b expected %b", i, obs, IDLE_OFF);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_vid_read;
        logic [6:0] exp_seq [3];
        exp_seq[0] = VID_ACC;
        exp_seq[1] = VID_FIN;
        exp_seq[2] = VID_PARK;
        bus_if.vid_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL vid_read cyc%0d: got %b expected %b", i + 1, obs, exp_seq[i]);
            end
            if (i == 1) bus_if.vid_req = 1'b0;
        end
    endtask

    task automatic test_cpu_write;
        logic [6:0] exp_seq [4];
        exp_seq[0] = IDLE_OFF;
        exp_seq[1] = CPU_WR;
        exp_seq[2] = CPU_WRFIN;
        exp_seq[3] = CPU_PARK;
        bus_if.cpu_req = 1'b1;
        bus_if.cpu_we  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL cpu_write cyc%0d: got %b expected %b", i + 1, obs, exp_seq[i]);
            end
            if (i == 2) begin
                bus_if.cpu_req = 1'b0;
                bus_if.cpu_we  = 1'b0;
            end
        end
    endtask

    // Parked on CPU with CPU served last: the first tie goes to video, then
    // grants alternate with a 4-cycle period (gap, access, access+ack, idle).
    task automatic test_fairness;
        int         n_cack;
        int         n_vack;
        logic [6:0] exp_v;
        logic       vid_turn;
        int         phase;
        n_cack = 0;
        n_vack = 0;
        bus_if.cpu_we  = 1'b0;
        bus_if.cpu_req = 1'b1;
        bus_if.vid_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            phase    = (c - 1) % 4;
            vid_turn = (((c - 1) / 4) % 2) == 0;
            case (phase)
                0:       exp_v = IDLE_OFF;
                1:       exp_v = vid_turn ? VID_ACC  : CPU_RD;
                2:       exp_v = vid_turn ? VID_FIN  : CPU_RDFIN;
                default: exp_v = vid_turn ? VID_PARK : CPU_PARK;
            endcase
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL fairness cyc%0d: got %b expected %b", c, obs, exp_v);
            end
            n_tests++;
            if (bus_if.sw_oe1_n === 1'b0 && bus_if.sw_oe2_n === 1'b0) begin
                n_fail++;
                $display("FAIL both_paths cyc%0d: sw_oe1_n=%b sw_oe2_n=%b required not both 0",
                         c, bus_if.sw_oe1_n, bus_if.sw_oe2_n);
            end
            if (bus_if.cpu_ack === 1'b1) n_cack++;
            if (bus_if.vid_ack === 1'b1) n_vack++;
        end
        bus_if.cpu_req = 1'b0;
        bus_if.vid_req = 1'b0;
        n_tests++;
        if (n_cack != 5 || n_vack != 5) begin
            n_fail++;
            $display("FAIL fair_counts: got cpu=%0d vid=%0d expected cpu=5 vid=5", n_cack, n_vack);
        end
        n_tests++;
        if ((n_cack - n_vack) > 1 || (n_vack - n_cack) > 1) begin
            n_fail++;
            $display("FAIL fair_balance: got diff %0d required <=1", n_cack - n_vack);
        end
    endtask

    task automatic test_back_to_back;
        logic       found;
        logic [6:0] exp_seq [5];
        exp_seq[0] = VID_ACC;
        exp_seq[1] = VID_FIN;
        exp_seq[2] = VID_PARK;
        exp_seq[3] = VID_ACC;
        exp_seq[4] = VID_FIN;
        // Move ownership to video first (bounded wait for its ack).
        found = 1'b0;
        bus_if.vid_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.vid_ack === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        bus_if.vid_req = 1'b0;
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_prime: got no vid_ack in 10 cycles, expected one");
        end
        @(negedge clk);
        n_tests++;
        if (obs !== VID_PARK) begin
            n_fail++;
            $display("FAIL b2b_parked: got %b expected %b", obs, VID_PARK);
        end
        // Request held across two accesses: no gap, ack spacing of 3.
        bus_if.vid_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got %b expected %b", i + 1, obs, exp_seq[i]);
            end
        end
        bus_if.vid_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== VID_PARK) begin
            n_fail++;
            $display("FAIL b2b_end: got %b expected %b", obs, VID_PARK);
        end
    endtask

    task automatic test_reset_mid_access;
        bus_if.cpu_we  = 1'b0;
        bus_if.cpu_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs !== IDLE_OFF) begin
            n_fail++;
            $display("FAIL rma_gap: got %b expected %b", obs, IDLE_OFF);
        end
        @(negedge clk);
        n_tests++;
        if (obs !== CPU_RD) begin
            n_fail++;
            $display("FAIL rma_first: got %b expected %b", obs, CPU_RD);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== IDLE_OFF) begin
            n_fail++;
            $display("FAIL rma_async: got %b expected %b", obs, IDLE_OFF);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== IDLE_OFF) begin
                n_fail++;
                $display("FAIL rma_hold cyc%0d: got %b expected %b", i, obs, IDLE_OFF);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== CPU_RD) begin
            n_fail++;
            $display("FAIL rma_restart: got %b expected %b", obs, CPU_RD);
        end
        @(negedge clk);
        n_tests++;
        if (obs !== CPU_RDFIN) begin
            n_fail++;
            $display("FAIL rma_ack: got %b expected %b", obs, CPU_RDFIN);
        end
        bus_if.cpu_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== CPU_PARK) begin
            n_fail++;
            $display("FAIL rma_park: got %b expected %b", obs, CPU_PARK);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_vid_read();
        test_cpu_write();
        test_fairness();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
